// File: rtl/stream_mux_arb_if.sv
// Stream bundle for stream_mux_arb: M input channels in, one registered stream out.
// The master modport is the multiplexer side; the slave modport is the environment
// that drives the input channels and consumes the output stream.
interface stream_mux_arb_if #(
    parameter int N = 16,
    parameter int M = 4
);
    localparam int SELW = $clog2(M);

    logic [M*N-1:0]  in_data;
    logic [M-1:0]    in_valid;
    logic [M-1:0]    in_last;
    logic [M-1:0]    in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [SELW-1:0] out_sel;
    logic            out_ready;

    modport master (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_mux_arb.sv
// Registered M-channel stream multiplexer with a built-in packet-locked arbiter.
// MODE=0 arbitrates round-robin from a rotating pointer, MODE=1 picks the lowest
// valid index. Once a multi-beat packet starts, its channel owns the output until
// the in_last beat is accepted.
module stream_mux_arb #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_mux_arb_if.master  bus
);
    localparam int SELW = $clog2(M);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] cur;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            load;
    logic            accept;
    logic            accept_last;
    logic [SELW-1:0] next_ptr;

    // Channel index base+off folded back into 0..M-1 (off < M, so one subtraction suffices).
    function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= M) s = s - M;
        return SELW'(s);
    endfunction

    // Output register can take a new beat when empty or being drained this cycle.
    assign load = ~bus.out_valid | bus.out_ready;

    // Grant selection: locked channel while a packet is open, otherwise arbitrate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_vld = 1'b0;
        if (state == BUSY) begin
            grant     = cur;
            grant_vld = 1'b1;
        end else if (MODE == 1) begin
            // Scan downward so the lowest valid index is the last (winning) assignment.
            for (int i = M - 1; i >= 0; i--) begin
                if (bus.in_valid[i]) begin
                    grant     = SELW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            // Same trick relative to ptr: the first valid at/after ptr wins.
            for (int k = M - 1; k >= 0; k--) begin
                if (bus.in_valid[wrap_idx(ptr, k)]) begin
                    grant     = wrap_idx(ptr, k);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // One-hot ready to the granted channel only; forced low while reset is asserted.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && load && grant_vld) bus.in_ready[grant] = 1'b1;
    end

    assign accept      = grant_vld & load & bus.in_valid[grant];
    assign accept_last = bus.in_last[grant];
    assign next_ptr    = wrap_idx(grant, 1);

    // Arbiter FSM and registered output stage, updated together on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cur           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (load) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            bus.out_valid <= accept;
            if (accept) begin
                bus.out_data <= bus.in_data[int'(grant)*N +: N];
                bus.out_sel  <= grant;
                bus.out_last <= accept_last;
                if (accept_last) begin
                    state <= IDLE;
                    ptr   <= next_ptr;
                end else begin
                    state <= BUSY;
                    cur   <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb. Three instances (M=4 round-robin,
// M=4 fixed priority, M=3 round-robin) run side by side; a per-instance
// behavioural model predicts every output each cycle, and directed phases add
// hand-computed expectations for reset, fairness, locking, backpressure and wrap.
module tb_stream_mux_arb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus per unit (unit 2 only uses the low 3 channels).
    logic [3:0]  s_valid [3];
    logic [3:0]  s_last  [3];
    logic        s_ordy  [3];
    logic [15:0] s_data  [3][4];

    // DUT outputs gathered per unit.
    logic [3:0]  d_rdy [3];
    logic        d_ov  [3];
    logic        d_ol  [3];
    logic [15:0] d_od  [3];
    logic [1:0]  d_os  [3];

    stream_mux_arb_if #(.N(16), .M(4)) if0 ();
    stream_mux_arb_if #(.N(16), .M(4)) if1 ();
    stream_mux_arb_if #(.N(16), .M(3)) if2 ();

    stream_mux_arb #(.N(16), .M(4), .MODE(0)) dut_rr4 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    stream_mux_arb #(.N(16), .M(4), .MODE(1)) dut_fp4 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    stream_mux_arb #(.N(16), .M(3), .MODE(0)) dut_rr3 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    assign if0.in_valid  = s_valid[0];
    assign if0.in_last   = s_last[0];
    assign if0.out_ready = s_ordy[0];
    assign if0.in_data   = {s_data[0][3], s_data[0][2], s_data[0][1], s_data[0][0]};
    assign if1.in_valid  = s_valid[1];
    assign if1.in_last   = s_last[1];
    assign if1.out_ready = s_ordy[1];
    assign if1.in_data   = {s_data[1][3], s_data[1][2], s_data[1][1], s_data[1][0]};
    assign if2.in_valid  = s_valid[2][2:0];
    assign if2.in_last   = s_last[2][2:0];
    assign if2.out_ready = s_ordy[2];
    assign if2.in_data   = {s_data[2][2], s_data[2][1], s_data[2][0]};

    assign d_rdy[0] = if0.in_ready;
    assign d_rdy[1] = if1.in_ready;
    assign d_rdy[2] = {1'b0, if2.in_ready};
    assign d_ov[0] = if0.out_valid;  assign d_ov[1] = if1.out_valid;  assign d_ov[2] = if2.out_valid;
    assign d_ol[0] = if0.out_last;   assign d_ol[1] = if1.out_last;   assign d_ol[2] = if2.out_last;
    assign d_od[0] = if0.out_data;   assign d_od[1] = if1.out_data;   assign d_od[2] = if2.out_data;
    assign d_os[0] = if0.out_sel;    assign d_os[1] = if1.out_sel;    assign d_os[2] = if2.out_sel;

    // Behavioural model: open packet channel (-1 = none), rotating pointer, output register.
    typedef struct {
        int          open;
        int          ptr;
        bit          ov;
        logic [15:0] od;
        bit          ol;
        int          os;
    } mdl_t;

    mdl_t mdl [3];
    int   m_of    [3] = '{4, 4, 3};
    int   mode_of [3] = '{0, 1, 0};
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model(input int u);
        mdl[u].open = -1;
        mdl[u].ptr  = 0;
        mdl[u].ov   = 1'b0;
        mdl[u].od   = '0;
        mdl[u].ol   = 1'b0;
        mdl[u].os   = 0;
    endtask

    // Channel that owns the output this cycle, or -1.
    function automatic int mdl_grant(input int u);
        int c;
        if (mdl[u].open >= 0) return mdl[u].open;
        for (int k = 0; k < m_of[u]; k++) begin
            c = (mode_of[u] == 1) ? k : (mdl[u].ptr + k) % m_of[u];
            if (s_valid[u][c]) return c;
        end
        return -1;
    endfunction

    task automatic compare_all();
        int       g;
        bit       ld;
        logic [3:0] er;
        for (int u = 0; u < 3; u++) begin
            ld = !mdl[u].ov || s_ordy[u];
            g  = mdl_grant(u);
            er = (rst_n && ld && g >= 0) ? 4'(1 << g) : 4'b0;
            check($sformatf("u%0d in_ready", u), 32'(d_rdy[u]), 32'(er));
            check($sformatf("u%0d out_valid", u), 32'(d_ov[u]), 32'(mdl[u].ov));
            check($sformatf("u%0d out_data", u), 32'(d_od[u]), 32'(mdl[u].od));
            check($sformatf("u%0d out_last", u), 32'(d_ol[u]), 32'(mdl[u].ol));
            check($sformatf("u%0d out_sel", u), 32'(d_os[u]), 32'(mdl[u].os));
        end
    endtask

    task automatic step_all();
        int g;
        bit ld;
        for (int u = 0; u < 3; u++) begin
            if (!rst_n) begin
                reset_model(u);
            end else begin
                ld = !mdl[u].ov || s_ordy[u];
                g  = mdl_grant(u);
                if (ld) begin
                    if (g >= 0 && s_valid[u][g]) begin
                        mdl[u].ov = 1'b1;
                        mdl[u].od = s_data[u][g];
                        mdl[u].ol = s_last[u][g];
                        mdl[u].os = g;
                        if (s_last[u][g]) begin
                            mdl[u].open = -1;
                            mdl[u].ptr  = (g + 1) % m_of[u];
                        end else begin
                            mdl[u].open = g;
                        end
                    end else begin
                        mdl[u].ov = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock: compare on the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        step_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_unit(input int u);
        s_valid[u] = '0;
        s_last[u]  = '0;
        s_ordy[u]  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            reset_model(u);
            s_valid[u] = 4'hF;
            s_last[u]  = 4'hF;
            s_ordy[u]  = 1'b1;
            for (int c = 0; c < 4; c++) s_data[u][c] = 16'(16'h1000 * (u + 1) + c);
        end

        // Reset holds outputs clear and ready low even with every channel valid.
        cycle();
        cycle();
        check("reset out_valid", 32'(d_ov[0]), 0);
        check("reset out_data", 32'(d_od[0]), 0);
        check("reset in_ready", 32'(d_rdy[0]), 0);
        check("reset in_ready fp", 32'(d_rdy[1]), 0);

        // Round-robin fairness on the M=4 instance.
        rst_n = 1'b1;
        idle_unit(1);
        idle_unit(2);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr seq out_sel", 32'(d_os[0]), 32'(i % 4));
            check("rr seq out_valid", 32'(d_ov[0]), 1);
        end

        // Asynchronous reset in the middle of a cycle while out_valid is high.
        check("pre reset out_valid", 32'(d_ov[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(d_ov[0]), 0);
        check("async rst out_sel", 32'(d_os[0]), 0);
        check("async rst in_ready", 32'(d_rdy[0]), 0);
        for (int u = 0; u < 3; u++) reset_model(u);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pointer back at 0 after release: channel 0 wins with all valid.
        #1 check("post reset grant", 32'(d_rdy[0]), 32'h1);
        cycle();                                   // ch0 single beat, ptr -> 1
        s_valid[0] = 4'b0010; s_last[0] = 4'b0010;
        cycle();                                   // ch1 single beat, ptr -> 2

        // Packet lock: ch2 three beats while ch0 stays valid.
        s_valid[0] = 4'b0101;
        for (int b = 0; b < 3; b++) begin
            s_last[0]    = (b == 2) ? 4'b0101 : 4'b0001;
            s_data[0][2] = 16'(16'h2200 + b);
            #1;
            check("lock in_ready", 32'(d_rdy[0]), 32'b0100);
            cycle();
            check("lock out_sel", 32'(d_os[0]), 2);
            check("lock out_data", 32'(d_od[0]), 32'(16'h2200 + b));
        end
        check("lock out_last", 32'(d_ol[0]), 1);
        s_valid[0] = 4'b0001;
        #1 check("wrap to ch0 in_ready", 32'(d_rdy[0]), 32'b0001);
        cycle();
        check("wrap to ch0 out_sel", 32'(d_os[0]), 0);

        // Backpressure: output held for 5 cycles, then the next beat loads at once.
        s_valid[0] = 4'b0010; s_last[0] = 4'b0010; s_data[0][1] = 16'hA5A5;
        cycle();
        check("bp first beat", 32'(d_od[0]), 32'hA5A5);
        s_data[0][1] = 16'h1234;
        s_ordy[0]    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp in_ready low", 32'(d_rdy[0]), 0);
            cycle();
            check("bp hold data", 32'(d_od[0]), 32'hA5A5);
            check("bp hold valid", 32'(d_ov[0]), 1);
        end
        s_ordy[0] = 1'b1;
        #1 check("bp release ready", 32'(d_rdy[0]), 32'b0010);
        cycle();
        check("bp next beat", 32'(d_od[0]), 32'h1234);
        s_valid[0] = '0;
        cycle();
        check("bp drained valid", 32'(d_ov[0]), 0);
        check("bp drained data hold", 32'(d_od[0]), 32'h1234);
        idle_unit(0);

        // Fixed priority: ch1 beats ch3 until ch1 drops.
        s_valid[1] = 4'b1010; s_last[1] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("fp out_sel ch1", 32'(d_os[1]), 1);
        end
        s_valid[1] = 4'b1000;
        cycle();
        check("fp out_sel ch3", 32'(d_os[1]), 3);
        idle_unit(1);

        // M=3: gap inside a ch2 packet, then pointer wraps to 0.
        s_valid[2] = 4'b0010; s_last[2] = 4'b0010;
        cycle();                                   // ch1 single beat, ptr -> 2
        s_valid[2] = 4'b0101; s_last[2] = 4'b0000;
        #1 check("m3 start ch2", 32'(d_rdy[2]), 32'b0100);
        cycle();
        check("m3 first beat sel", 32'(d_os[2]), 2);
        s_valid[2] = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            #1 check("m3 gap in_ready", 32'(d_rdy[2]), 32'b0100);
            cycle();
            check("m3 gap out_valid", 32'(d_ov[2]), 0);
        end
        s_valid[2] = 4'b0111; s_last[2] = 4'b0100;
        #1 check("m3 last beat ready", 32'(d_rdy[2]), 32'b0100);
        cycle();
        check("m3 last out_last", 32'(d_ol[2]), 1);
        s_valid[2] = 4'b0011; s_last[2] = 4'b0011;
        #1 check("m3 ptr wrapped", 32'(d_rdy[2]), 32'b0001);
        cycle();
        check("m3 wrap out_sel", 32'(d_os[2]), 0);

        // Randomized traffic on all three instances against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int u = 0; u < 3; u++) begin
                s_valid[u] = 4'($urandom);
                s_last[u]  = 4'($urandom) & 4'($urandom);
                s_ordy[u]  = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 4; c++) s_data[u][c] = 16'($urandom);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
